irq_timer: RTL and testbench
============================

IRQ_TIMER -- requirements
Module: irq_timer

Interface
REQ-001 SHALL have parameter DEFAULT_PRESET, default 32'd0, giving the PRESET reset value.
REQ-002 SHALL have port clk, input, 1 bit; the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit; one clock; reset is asynchronous and active-low (0 = reset asserted).
REQ-004 SHALL have port we, input, 1 bit; register write strobe, sampled at the clk rising edge.
REQ-005 SHALL have port addr, input, 2 bits; word select: 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = reserved.
REQ-006 SHALL have port wdata, input, 32 bits; write data.
REQ-007 SHALL have port rdata, output, 32 bits; combinational read of the register selected by addr.
REQ-008 SHALL have port irq, output, 1 bit; interrupt request, wired to CP0 HWInt[2].

Function
REQ-009 SHALL define CTRL[0] = EN, CTRL[2:1] = MODE, CTRL[3] = IM, and CTRL[31:4] reading 0.
REQ-010 SHALL decode MODE 00 as one-shot and 01 as auto-reload, and SHALL treat MODE 10 and 11 as one-shot.
REQ-011 SHALL hold a 32-bit PRESET and a 32-bit COUNT, and SHALL ignore writes to COUNT and to address 3.
REQ-012 SHALL return rdata = {28'b0, CTRL[3:0]}, PRESET, COUNT or 0 for addr 0, 1, 2 or 3 respectively.
REQ-013 SHALL drive irq = IM & irq_flag, where irq_flag is an internal register.
REQ-014 SHALL implement the states IDLE, LOAD, CNT and INT.
REQ-015 In IDLE, SHALL go to LOAD if EN = 1, otherwise stay in IDLE.
REQ-016 In LOAD, SHALL set COUNT <= PRESET and go to CNT.
REQ-017 In CNT with EN = 0, SHALL go to IDLE with COUNT held.
REQ-018 In CNT with EN = 1 and COUNT > 1, SHALL set COUNT <= COUNT - 1 and stay in CNT.
REQ-019 In CNT with EN = 1 and COUNT <= 1, SHALL set COUNT <= 0 and irq_flag <= 1, and go to INT.
REQ-020 In INT with one-shot mode, SHALL set EN <= 0, hold irq_flag, and go to IDLE.
REQ-021 In INT with auto-reload mode, SHALL set irq_flag <= 0 (a one-cycle pulse), keep EN, and go to IDLE, so the count reloads automatically.
REQ-022 SHALL clear irq_flag on any CTRL write, and that clear SHALL take priority over a same-edge set.
REQ-023 On a same-edge CPU CTRL write and INT EN-clear, the CPU write value of EN SHALL win.
REQ-024 A PRESET write SHALL NOT affect COUNT until the next LOAD, and on a same-edge PRESET write and LOAD, LOAD SHALL use the old PRESET.
REQ-025 SHALL make the decrement modulo-free: COUNT never wraps below 0, and PRESET = 0 and PRESET = 1 both reach INT on the first CNT cycle.
REQ-026 Latency: with EN written at edge E0 and PRESET = P >= 1, SHALL give LOAD after E1, COUNT = P after E2, COUNT = 0 with irq_flag = 1 after E(P+2), and SHALL NOT assert irq before that.
REQ-027 In auto-reload mode, the irq_flag pulse period SHALL be P + 3 cycles for P >= 1.

Reset
REQ-028 While reset = 0, regardless of clk, SHALL force state = IDLE, CTRL = 0, PRESET = DEFAULT_PRESET, COUNT = 0, irq_flag = 0 and irq = 0.
REQ-029 A reset asserted mid-count SHALL abort the count with no irq, and after release the block SHALL stay in IDLE until EN is written.
REQ-030 Reset release SHALL be synchronised by the system, and the block SHALL act on its first clk edge after release.

Verification
REQ-031 One-shot: PRESET=5, CTRL=0x9 -> COUNT 5,4,3,2,1,0 on edges E2..E7; irq=1 from E7 and held; CTRL reads 0x8 (EN cleared); writing CTRL=0x8 drops irq next edge.
REQ-032 Auto-reload: PRESET=3, CTRL=0xB -> irq high for exactly 1 cycle every 6 cycles across 3 periods; EN stays 1.
REQ-033 Masked: PRESET=2, CTRL=0x1 -> COUNT reaches 0, irq stays 0; then CTRL=0x8 (no EN) -> irq_flag is cleared, so irq stays 0.
REQ-034 Disable mid-count: PRESET=10, CTRL=0x9, CTRL=0x8 when COUNT=6 -> COUNT freezes at 6 and no irq; re-enabling reloads 10.
REQ-035 Boundary: PRESET=0 with CTRL=0x9 -> irq after E3; with PRESET=0xFFFFFFFF, reads COUNT=0xFFFFFFFE one edge after LOAD; writes to COUNT and addr 3 are ignored, and addr 3 reads 0.
REQ-036 Reset: reset=0 while COUNT=4 in CNT -> all registers are at reset values immediately (no clk edge), irq=0, and the block stays in IDLE after release.

Source files
------------

// File: rtl/irq_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : irq_timer
//  Description : 32-bit down-counting interrupt timer with a small register
//                file (CTRL / PRESET / COUNT). Supports one-shot and
//                auto-reload modes and a maskable interrupt request.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_timer #(
    parameter logic [31:0] DEFAULT_PRESET = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [1:0] c_ADDR_CTRL   = 2'd0;
    localparam logic [1:0] c_ADDR_PRESET = 2'd1;
    localparam logic [1:0] c_ADDR_COUNT  = 2'd2;
    localparam logic [1:0] c_MODE_AUTO   = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_en;
    logic [1:0]  r_mode;
    logic        r_im;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_irq_flag;

    state_t      w_state_nxt;
    logic        w_en_nxt;
    logic [1:0]  w_mode_nxt;
    logic        w_im_nxt;
    logic [31:0] w_preset_nxt;
    logic [31:0] w_count_nxt;
    logic        w_irq_flag_nxt;
    logic        w_auto;
    logic        w_unused_wdata;

    // Only MODE 01 reloads; every other encoding behaves as one-shot.
    assign w_auto         = (r_mode == c_MODE_AUTO);
    assign w_unused_wdata = ^wdata[31:4];

    // Register all timer state; reset acts immediately, independent of clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_en       <= 1'b0;
            r_mode     <= 2'b00;
            r_im       <= 1'b0;
            r_preset   <= DEFAULT_PRESET;
            r_count    <= 32'd0;
            r_irq_flag <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_en       <= w_en_nxt;
            r_mode     <= w_mode_nxt;
            r_im       <= w_im_nxt;
            r_preset   <= w_preset_nxt;
            r_count    <= w_count_nxt;
            r_irq_flag <= w_irq_flag_nxt;
        end
    end

    // Next-state logic: FSM updates first, CPU writes applied last so they win.
    always_comb begin
        w_state_nxt    = r_state;
        w_en_nxt       = r_en;
        w_mode_nxt     = r_mode;
        w_im_nxt       = r_im;
        w_preset_nxt   = r_preset;
        w_count_nxt    = r_count;
        w_irq_flag_nxt = r_irq_flag;

        case (r_state)
            IDLE: begin
                if (r_en) begin
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                // Uses the registered PRESET, so a same-edge write lands next time.
                w_count_nxt = r_preset;
                w_state_nxt = CNT;
            end
            CNT: begin
                if (!r_en) begin
                    w_state_nxt = IDLE;
                end else if (r_count > 32'd1) begin
                    w_count_nxt = r_count - 32'd1;
                end else begin
                    // Covers PRESET 0 and 1 alike; never wraps below zero.
                    w_count_nxt    = 32'd0;
                    w_irq_flag_nxt = 1'b1;
                    w_state_nxt    = INT;
                end
            end
            INT: begin
                if (w_auto) begin
                    w_irq_flag_nxt = 1'b0;
                end else begin
                    w_en_nxt = 1'b0;
                end
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (we) begin
            case (addr)
                c_ADDR_CTRL: begin
                    w_en_nxt       = wdata[0];
                    w_mode_nxt     = wdata[2:1];
                    w_im_nxt       = wdata[3];
                    w_irq_flag_nxt = 1'b0;
                end
                c_ADDR_PRESET: begin
                    w_preset_nxt = wdata;
                end
                default: begin
                    // COUNT and the reserved word are read-only.
                end
            endcase
        end
    end

    // Combinational register read-back.
    always_comb begin
        rdata = 32'd0;
        case (addr)
            c_ADDR_CTRL:   rdata = {28'd0, r_im, r_mode, r_en};
            c_ADDR_PRESET: rdata = r_preset;
            c_ADDR_COUNT:  rdata = r_count;
            default:       rdata = 32'd0;
        endcase
    end

    assign irq = r_im & r_irq_flag;

endmodule
`default_nettype wire

// File: tb/tb_irq_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_irq_timer
//  Description : Self-checking bench for irq_timer (scoreboard of expected
//                COUNT / irq values per clock edge plus directed checks).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_timer;

    localparam logic [31:0] c_DEFAULT_PRESET = 32'h0000_1234;

    logic        clk;
    logic        reset;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int n_vec;
    int n_err;

    typedef struct {
        logic [31:0] count;
        logic        irq;
    } exp_t;

    exp_t sb[$];

    irq_timer #(
        .DEFAULT_PRESET(c_DEFAULT_PRESET)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; land 1 ns after it so reads are away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        we    = 1'b1;
        addr  = a;
        wdata = d;
        tick();
        we    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        we    = 1'b0;
        addr  = 2'd0;
        wdata = 32'd0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        rd(2'd0, d); n_vec++;
        if (d !== 32'd0) begin n_err++; $display("FAIL reset_ctrl: got %0h expected 0", d); end
        rd(2'd1, d); n_vec++;
        if (d !== c_DEFAULT_PRESET) begin n_err++; $display("FAIL reset_preset: got %0h expected %0h", d, c_DEFAULT_PRESET); end
        rd(2'd2, d); n_vec++;
        if (d !== 32'd0) begin n_err++; $display("FAIL reset_count: got %0h expected 0", d); end
        n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b expected 0", irq); end
    endtask

    task automatic test_oneshot();
        logic [31:0] d;
        exp_t e;
        do_reset();
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        for (int k = 1; k <= 8; k++) begin
            e.count = (k < 2 || k >= 7) ? 32'd0 : 32'(7 - k);
            e.irq   = (k >= 7);
            sb.push_back(e);
        end
        while (sb.size() > 0) begin
            tick();
            e = sb.pop_front();
            rd(2'd2, d); n_vec++;
            if (d !== e.count) begin n_err++; $display("FAIL oneshot_count: got %0h expected %0h", d, e.count); end
            n_vec++;
            if (irq !== e.irq) begin n_err++; $display("FAIL oneshot_irq: got %b expected %b", irq, e.irq); end
        end
        rd(2'd0, d); n_vec++;
        if (d !== 32'h8) begin n_err++; $display("FAIL oneshot_ctrl: got %0h expected 8", d); end
        tick(); tick(); n_vec++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL oneshot_hold: got %b expected 1", irq); end
        wr(2'd0, 32'h8); n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL oneshot_clear: got %b expected 0", irq); end
    endtask

    task automatic test_autoreload();
        logic [31:0] d;
        exp_t e;
        int ph;
        do_reset();
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        for (int k = 1; k <= 20; k++) begin
            ph      = (k - 2) % 6;
            e.count = (k < 2) ? 32'd0 : ((ph < 3) ? 32'(3 - ph) : 32'd0);
            e.irq   = (k >= 2) && (ph == 3);
            sb.push_back(e);
        end
        while (sb.size() > 0) begin
            tick();
            e = sb.pop_front();
            rd(2'd2, d); n_vec++;
            if (d !== e.count) begin n_err++; $display("FAIL auto_count: got %0h expected %0h", d, e.count); end
            n_vec++;
            if (irq !== e.irq) begin n_err++; $display("FAIL auto_irq: got %b expected %b", irq, e.irq); end
        end
        rd(2'd0, d); n_vec++;
        if (d !== 32'hB) begin n_err++; $display("FAIL auto_ctrl: got %0h expected b", d); end
    endtask

    task automatic test_masked();
        logic [31:0] d;
        do_reset();
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        for (int k = 0; k < 6; k++) begin
            tick(); n_vec++;
            if (irq !== 1'b0) begin n_err++; $display("FAIL masked_irq: got %b expected 0", irq); end
        end
        rd(2'd2, d); n_vec++;
        if (d !== 32'd0) begin n_err++; $display("FAIL masked_count: got %0h expected 0", d); end
        wr(2'd0, 32'h8); n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL masked_unmask: got %b expected 0", irq); end
        tick(); n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL masked_unmask2: got %b expected 0", irq); end
    endtask

    task automatic test_disable();
        logic [31:0] d;
        do_reset();
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        for (int k = 0; k < 5; k++) tick();
        rd(2'd2, d); n_vec++;
        if (d !== 32'd7) begin n_err++; $display("FAIL disable_pre: got %0h expected 7", d); end
        wr(2'd0, 32'h8);
        for (int k = 0; k < 4; k++) begin
            tick();
            rd(2'd2, d); n_vec++;
            if (d !== 32'd6) begin n_err++; $display("FAIL disable_freeze: got %0h expected 6", d); end
            n_vec++;
            if (irq !== 1'b0) begin n_err++; $display("FAIL disable_irq: got %b expected 0", irq); end
        end
        wr(2'd0, 32'h9);
        tick(); tick();
        rd(2'd2, d); n_vec++;
        if (d !== 32'd10) begin n_err++; $display("FAIL disable_reload: got %0h expected a", d); end
    endtask

    task automatic test_boundary();
        logic [31:0] d;
        do_reset();
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        tick(); tick(); n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL zero_early: got %b expected 0", irq); end
        tick(); n_vec++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL zero_irq: got %b expected 1", irq); end
        do_reset();
        wr(2'd1, 32'hFFFF_FFFF);
        wr(2'd0, 32'h1);
        tick(); tick();
        rd(2'd2, d); n_vec++;
        if (d !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL max_load: got %0h expected ffffffff", d); end
        tick();
        rd(2'd2, d); n_vec++;
        if (d !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL max_dec: got %0h expected fffffffe", d); end
        wr(2'd2, 32'h0000_0123);
        rd(2'd2, d); n_vec++;
        if (d !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL count_ro: got %0h expected fffffffd", d); end
        wr(2'd3, 32'hDEAD_BEEF);
        rd(2'd3, d); n_vec++;
        if (d !== 32'd0) begin n_err++; $display("FAIL addr3_read: got %0h expected 0", d); end
        rd(2'd1, d); n_vec++;
        if (d !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL addr3_preset: got %0h expected ffffffff", d); end
        rd(2'd0, d); n_vec++;
        if (d !== 32'h1) begin n_err++; $display("FAIL addr3_ctrl: got %0h expected 1", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        // PRESET write on the LOAD edge must not reach COUNT.
        do_reset();
        wr(2'd1, 32'd4);
        wr(2'd0, 32'h1);
        tick();
        wr(2'd1, 32'd9);
        rd(2'd2, d); n_vec++;
        if (d !== 32'd4) begin n_err++; $display("FAIL load_old_preset: got %0h expected 4", d); end
        rd(2'd1, d); n_vec++;
        if (d !== 32'd9) begin n_err++; $display("FAIL load_new_preset: got %0h expected 9", d); end
        // CTRL write on the flag-set edge, then on the INT edge.
        do_reset();
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h9);
        tick(); tick();
        wr(2'd0, 32'h9); n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL clear_priority: got %b expected 0", irq); end
        wr(2'd0, 32'h9);
        rd(2'd0, d); n_vec++;
        if (d !== 32'h9) begin n_err++; $display("FAIL en_write_wins: got %0h expected 9", d); end
        tick(); tick(); tick(); n_vec++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL rearm_irq: got %b expected 1", irq); end
    endtask

    task automatic test_reset_midcount();
        logic [31:0] d;
        do_reset();
        wr(2'd1, 32'd8);
        wr(2'd0, 32'h9);
        for (int k = 0; k < 6; k++) tick();
        rd(2'd2, d); n_vec++;
        if (d !== 32'd4) begin n_err++; $display("FAIL mid_count: got %0h expected 4", d); end
        reset = 1'b0;
        #1;
        rd(2'd0, d); n_vec++;
        if (d !== 32'd0) begin n_err++; $display("FAIL async_ctrl: got %0h expected 0", d); end
        rd(2'd1, d); n_vec++;
        if (d !== c_DEFAULT_PRESET) begin n_err++; $display("FAIL async_preset: got %0h expected %0h", d, c_DEFAULT_PRESET); end
        rd(2'd2, d); n_vec++;
        if (d !== 32'd0) begin n_err++; $display("FAIL async_count: got %0h expected 0", d); end
        n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL async_irq: got %b expected 0", irq); end
        reset = 1'b1;
        for (int k = 0; k < 12; k++) tick();
        rd(2'd2, d); n_vec++;
        if (d !== 32'd0) begin n_err++; $display("FAIL post_count: got %0h expected 0", d); end
        rd(2'd0, d); n_vec++;
        if (d !== 32'd0) begin n_err++; $display("FAIL post_ctrl: got %0h expected 0", d); end
        n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL post_irq: got %b expected 0", irq); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        we    = 1'b0;
        addr  = 2'd0;
        wdata = 32'd0;
        test_reset();
        test_oneshot();
        test_autoreload();
        test_masked();
        test_disable();
        test_boundary();
        test_back_to_back();
        test_reset_midcount();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
